// File: rtl/gauss_pkg.sv
// Shared constants and types for the 3x3 Gaussian window filter.
package gauss_pkg;

  localparam int LAT            = 3;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int SUM_GROW       = 4;
  localparam int SUM_W          = DEF_DATA_WIDTH + SUM_GROW;

  // 1-2-1 separable kernel; the full 3x3 kernel sums to 16.
  localparam int K_OUTER    = 1;
  localparam int K_INNER    = 2;
  localparam int ROUND_BIAS = 8;
  localparam int NORM_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } gauss_state_t;

endpackage

// File: rtl/gauss_row_sum.sv
// Registered 1-2-1 weighted adder: sum = (a + 2b + c + BIAS) >> SHIFT.
module gauss_row_sum
  import gauss_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int BIAS  = 0,
  parameter int SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IN_W-1:0]         tap_a,
  input  logic [IN_W-1:0]         tap_b,
  input  logic [IN_W-1:0]         tap_c,
  output logic [IN_W+1-SHIFT:0]   sum
);

  localparam int FULL_W = IN_W + 2;
  localparam int OUT_W  = FULL_W - SHIFT;

  logic [FULL_W-1:0] full_sum;

  always_comb begin
    full_sum = FULL_W'(K_OUTER) * FULL_W'(tap_a)
             + FULL_W'(K_INNER) * FULL_W'(tap_b)
             + FULL_W'(K_OUTER) * FULL_W'(tap_c)
             + FULL_W'(BIAS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else begin
      sum <= OUT_W'(full_sum >> SHIFT);
    end
  end

endmodule

// File: rtl/gauss3x3_window.sv
// 3x3 Gaussian window on a column stream, fixed latency LAT.
// Build option: GAUSS_BORDER_ZERO_EN makes border pixels output 0 instead of the raw centre tap.
module gauss3x3_window
  import gauss_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_W      = 480,
  parameter int IMG_H      = 272
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_vs,
  input  logic                    in_de,
  input  logic [3*DATA_WIDTH-1:0] in_col,
  output logic                    out_vs,
  output logic                    out_de,
  output logic [DATA_WIDTH-1:0]   out_data
);

  localparam int DW   = DATA_WIDTH;
  localparam int RS_W = DW + 2;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  gauss_state_t      state, state_next;
  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt;
  logic              accept;
  logic              col_last;
  logic              border_s;

  logic [3*DW-1:0]   w0, w1, w2;
  logic              border0;
  logic [DW-1:0]     centre1;
  logic              border1;
  logic [RS_W-1:0]   row_r [3];
  logic [RS_W-1:0]   st2_a, st2_b, st2_c;

  logic [LAT-1:0]    de_pipe;
  logic [LAT-1:0]    vs_pipe;

  always_comb begin
    accept   = in_de && (state != IDLE);
    col_last = (col_cnt == CW'(IMG_W - 1));
    border_s = (state != RUN) || (col_cnt < CW'(2));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_vs) state_next = FILL;
        else       state_next = IDLE;
      end
      FILL: begin
        if (in_vs)                                          state_next = FILL;
        else if (accept && col_last && row_cnt == RW'(1))   state_next = RUN;
        else                                                state_next = FILL;
      end
      RUN: begin
        if (in_vs) state_next = FILL;
        else       state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Frame position; in_vs clears and wins over a same-cycle in_de.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (in_vs) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_cnt <= '0;
        if (row_cnt != RW'(IMG_H - 1)) begin
          row_cnt <= row_cnt + RW'(1);
        end
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  // Stage 0: horizontal shift of the column registers; holds across in_de gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0      <= '0;
      w1      <= '0;
      w2      <= '0;
      border0 <= 1'b0;
    end else if (accept) begin
      w0      <= in_col;
      w1      <= w0;
      w2      <= w1;
      border0 <= border_s;
    end
  end

  // Stage 1: horizontal 1-2-1 per line (k=0 newest, k=2 oldest).
  for (genvar k = 0; k < 3; k++) begin : g_row
    gauss_row_sum #(
      .IN_W (DW),
      .BIAS (0),
      .SHIFT(0)
    ) u_row (
      .clk  (clk),
      .rst_n(rst_n),
      .tap_a(w2[k*DW +: DW]),
      .tap_b(w1[k*DW +: DW]),
      .tap_c(w0[k*DW +: DW]),
      .sum  (row_r[k])
    );
  end

  // Stage 1 side band: centre tap and border flag travel with the row sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      centre1 <= '0;
      border1 <= 1'b0;
    end else begin
      centre1 <= w1[DW +: DW];
      border1 <= border0;
    end
  end

  // Border pixels reuse the vertical adder: 4c,4c,4c sums to 16c, so /16 returns c exactly.
  always_comb begin
    st2_a = row_r[2];
    st2_b = row_r[1];
    st2_c = row_r[0];
    if (border1) begin
`ifdef GAUSS_BORDER_ZERO_EN
      st2_a = '0;
      st2_b = '0;
      st2_c = '0;
`else
      st2_a = {centre1, 2'b00};
      st2_b = {centre1, 2'b00};
      st2_c = {centre1, 2'b00};
`endif
    end else begin
      st2_a = row_r[2];
      st2_b = row_r[1];
      st2_c = row_r[0];
    end
  end

  // Stage 2: vertical 1-2-1 with rounding and /16 straight into the output register.
  gauss_row_sum #(
    .IN_W (RS_W),
    .BIAS (ROUND_BIAS),
    .SHIFT(NORM_SHIFT)
  ) u_col (
    .clk  (clk),
    .rst_n(rst_n),
    .tap_a(st2_a),
    .tap_b(st2_b),
    .tap_c(st2_c),
    .sum  (out_data)
  );

  // Control delay line matching the three data stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_pipe <= '0;
      vs_pipe <= '0;
    end else begin
      de_pipe <= {de_pipe[LAT-2:0], accept};
      vs_pipe <= {vs_pipe[LAT-2:0], in_vs};
    end
  end

  assign out_de = de_pipe[LAT-1];
  assign out_vs = vs_pipe[LAT-1];

endmodule

// File: tb/tb_gauss3x3_window.sv
// Directed bench for gauss3x3_window on a reduced 8x5 frame.
module tb_gauss3x3_window;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 5;

  logic            clk;
  logic            rst_n;
  logic            in_vs;
  logic            in_de;
  logic [3*DW-1:0] in_col;
  logic            out_vs;
  logic            out_de;
  logic [DW-1:0]   out_data;

  int n_checks;
  int n_fail;
  int cyc;
  logic [DW-1:0] cap_data [$];
  int            cap_cyc  [$];
  int            vs_cyc   [$];
  int            exp_q    [$];
  int            prev_mid;
  int            t_vs;
  int            t_de;

  gauss3x3_window #(
    .DATA_WIDTH(DW),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vs   (in_vs),
    .in_de   (in_de),
    .in_col  (in_col),
    .out_vs  (out_vs),
    .out_de  (out_de),
    .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_de) begin
      cap_data.push_back(out_data);
      cap_cyc.push_back(cyc);
    end
    if (out_vs) vs_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Image content for line y (negative = above the frame), column x.
  function automatic int pix(input int pat, input int y, input int x);
    case (pat)
      0:       return 100;
      1:       return (y == 2 && x == 3) ? 160 : 0;
      2:       return 255;
      3:       return (y < 0) ? 0 : ((x * 29 + y * 53 + 7) % 256);
      default: return 0;
    endcase
  endfunction

  // Plain 2D convolution centred on line y-1, column x-1.
  function automatic int conv(input int pat, input int y, input int x);
    int k [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
    int acc = 0;
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        acc += k[dy][dx] * pix(pat, y - 2 + dy, x - 2 + dx);
    return (acc + 8) / 16;
  endfunction

  task automatic drive_frame(input int pat, input int gap, input int lead, input int npix);
    int k = 0;
    exp_q.delete();
    in_vs = 1'b1;
    t_vs  = cyc;
    tick();
    in_vs = 1'b0;
    repeat (lead) tick();
    for (int y = 0; y < H && k < npix; y++) begin
      for (int x = 0; x < W && k < npix; x++) begin
        in_de  = 1'b1;
        in_col = {DW'(pix(pat, y - 2, x)), DW'(pix(pat, y - 1, x)), DW'(pix(pat, y, x))};
        if (k == 0) t_de = cyc;
        if (y >= 2 && x >= 2) exp_q.push_back(conv(pat, y, x));
`ifdef GAUSS_BORDER_ZERO_EN
        else exp_q.push_back(0);
`else
        else exp_q.push_back(prev_mid);
`endif
        prev_mid = pix(pat, y - 1, x);
        k++;
        tick();
        if (gap > 0) begin
          in_de = 1'b0;
          repeat (gap) tick();
        end
      end
      if (k < npix) begin
        in_de = 1'b0;
        tick();
        tick();
      end
    end
    if (npix >= H * W) begin
      in_de = 1'b0;
      repeat (6) tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks += 3;
    if (out_de !== 1'b0)   begin n_fail++; $display("FAIL reset_out_de got %0b want 0", out_de); end
    if (out_vs !== 1'b0)   begin n_fail++; $display("FAIL reset_out_vs got %0b want 0", out_vs); end
    if (out_data !== 8'd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_flat();
    int base;
    for (int f = 0; f < 2; f++) begin
      base = cap_data.size();
      drive_frame(0, 0, 0, H * W);
      n_checks++;
      if (cap_data.size() - base !== H * W) begin
        n_fail++; $display("FAIL flat_count got %0d want %0d", cap_data.size() - base, H * W);
      end
      for (int i = 0; i < exp_q.size() && base + i < cap_data.size(); i++) begin
        n_checks++;
        if (cap_data[base + i] !== DW'(exp_q[i])) begin
          n_fail++; $display("FAIL flat_model idx %0d got %0d want %0d", i, cap_data[base + i], exp_q[i]);
        end
`ifndef GAUSS_BORDER_ZERO_EN
        if (f == 1) begin
          n_checks++;
          if (cap_data[base + i] !== 8'd100) begin
            n_fail++; $display("FAIL flat_const idx %0d got %0d want 100", i, cap_data[base + i]);
          end
        end
`endif
      end
    end
  endtask

  task automatic test_impulse();
    int base;
    int idx  [8] = '{19, 20, 27, 28, 29, 36, 37, 30};
    int want [8] = '{10, 20, 20, 40, 20, 20, 10, 0};
    base = cap_data.size();
    drive_frame(1, 0, 0, H * W);
    n_checks++;
    if (cap_data.size() - base !== H * W) begin
      n_fail++; $display("FAIL impulse_count got %0d want %0d", cap_data.size() - base, H * W);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (cap_data[base + idx[i]] !== DW'(want[i])) begin
          n_fail++; $display("FAIL impulse_tap idx %0d got %0d want %0d", idx[i], cap_data[base + idx[i]], want[i]);
        end
      end
      for (int i = 0; i < H * W; i++) begin
        n_checks++;
        if (cap_data[base + i] !== DW'(exp_q[i])) begin
          n_fail++; $display("FAIL impulse_model idx %0d got %0d want %0d", i, cap_data[base + i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_max();
    int base;
    base = cap_data.size();
    drive_frame(2, 0, 0, H * W);
    n_checks++;
    if (cap_data.size() - base !== H * W) begin
      n_fail++; $display("FAIL max_count got %0d want %0d", cap_data.size() - base, H * W);
    end else begin
      for (int i = 0; i < H * W; i++) begin
        n_checks++;
        if (cap_data[base + i] !== DW'(exp_q[i])) begin
          n_fail++; $display("FAIL max_model idx %0d got %0d want %0d", i, cap_data[base + i], exp_q[i]);
        end
        if (i >= 2 * W && (i % W) >= 2) begin
          n_checks++;
          if (cap_data[base + i] !== 8'd255) begin
            n_fail++; $display("FAIL max_interior idx %0d got %0d want 255", i, cap_data[base + i]);
          end
        end
      end
    end
  endtask

  task automatic test_latency_gaps();
    int base;
    int vbase;
    int ref_vals [$];
    vbase = vs_cyc.size();
    base  = cap_data.size();
    drive_frame(3, 0, 4, H * W);
    n_checks += 3;
    if (vs_cyc.size() != vbase + 1) begin
      n_fail++; $display("FAIL vs_count got %0d want 1", vs_cyc.size() - vbase);
    end else if (vs_cyc[vbase] - t_vs !== 3) begin
      n_fail++; $display("FAIL vs_latency got %0d want 3", vs_cyc[vbase] - t_vs);
    end
    if (cap_data.size() - base !== H * W) begin
      n_fail++; $display("FAIL lat_count got %0d want %0d", cap_data.size() - base, H * W);
    end else if (cap_cyc[base] - t_de !== 3) begin
      n_fail++; $display("FAIL de_latency got %0d want 3", cap_cyc[base] - t_de);
    end
    if (t_de - t_vs !== 5) begin
      n_fail++; $display("FAIL lead_cycles got %0d want 5", t_de - t_vs);
    end
    for (int i = 0; i < H * W && base + i < cap_data.size(); i++) begin
      n_checks++;
      ref_vals.push_back(int'(cap_data[base + i]));
      if (cap_data[base + i] !== DW'(exp_q[i])) begin
        n_fail++; $display("FAIL ramp_model idx %0d got %0d want %0d", i, cap_data[base + i], exp_q[i]);
      end
    end
    base = cap_data.size();
    drive_frame(3, 1, 0, H * W);
    n_checks++;
    if (cap_data.size() - base !== H * W) begin
      n_fail++; $display("FAIL gap_count got %0d want %0d", cap_data.size() - base, H * W);
    end
    for (int i = 0; i < H * W && base + i < cap_data.size(); i++) begin
      n_checks++;
      if (cap_data[base + i] !== DW'(exp_q[i])) begin
        n_fail++; $display("FAIL gap_model idx %0d got %0d want %0d", i, cap_data[base + i], exp_q[i]);
      end
      if (i >= 1 && i < ref_vals.size()) begin
        n_checks++;
        if (int'(cap_data[base + i]) !== ref_vals[i]) begin
          n_fail++; $display("FAIL gap_vs_gapless idx %0d got %0d want %0d", i, cap_data[base + i], ref_vals[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    int vbase;
    drive_frame(3, 0, 0, 2 * W + 4);
    n_checks++;
    if (out_de !== 1'b1) begin n_fail++; $display("FAIL pre_reset_de got %0b want 1", out_de); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (out_de !== 1'b0)   begin n_fail++; $display("FAIL midreset_de got %0b want 0", out_de); end
    if (out_data !== 8'd0) begin n_fail++; $display("FAIL midreset_data got %0d want 0", out_data); end
    tick();
    tick();
    rst_n    = 1'b1;
    prev_mid = 0;
    base     = cap_data.size();
    vbase    = vs_cyc.size();
    for (int i = 0; i < 2 * W; i++) begin
      in_de  = 1'b1;
      in_col = {DW'(i * 3), DW'(i * 5 + 1), DW'(i * 7 + 2)};
      tick();
    end
    in_de = 1'b0;
    repeat (5) tick();
    n_checks += 2;
    if (cap_data.size() !== base) begin
      n_fail++; $display("FAIL idle_out_de got %0d outputs want 0", cap_data.size() - base);
    end
    if (vs_cyc.size() !== vbase) begin
      n_fail++; $display("FAIL idle_out_vs got %0d want 0", vs_cyc.size() - vbase);
    end
    base = cap_data.size();
    drive_frame(3, 0, 0, H * W);
    n_checks++;
    if (cap_data.size() - base !== H * W) begin
      n_fail++; $display("FAIL resume_count got %0d want %0d", cap_data.size() - base, H * W);
    end
    for (int i = 0; i < H * W && base + i < cap_data.size(); i++) begin
      n_checks++;
      if (cap_data[base + i] !== DW'(exp_q[i])) begin
        n_fail++; $display("FAIL resume_model idx %0d got %0d want %0d", i, cap_data[base + i], exp_q[i]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    prev_mid = 0;
    t_vs     = 0;
    t_de     = 0;
    rst_n    = 1'b0;
    in_vs    = 1'b0;
    in_de    = 1'b0;
    in_col   = '0;
    test_reset();
    test_flat();
    test_impulse();
    test_max();
    test_latency_gaps();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
